// File: rtl/ir_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ir_frame_decoder
// Purpose  : IR receiver front end: synchronises the line, times marks/spaces,
//            decodes spaces into bits and emits whole frames or error pulses.
// Revision : 1.0
// ============================================================================
module ir_frame_decoder #(
  parameter int FRAME_BITS  = 32,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_SPACE   = 200,
  parameter int BIT1_THRESH = 1000,
  parameter int TIMEOUT     = 177127
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ir_in,
  output logic [FRAME_BITS-1:0]             frame_data,
  output logic                              frame_valid,
  output logic                              error,
  output logic                              err_timeout,
  output logic                              busy,
  output logic [$clog2(FRAME_BITS+1)-1:0]   bit_count
);

  localparam int              c_bc_w      = $clog2(FRAME_BITS + 1);
  localparam longint unsigned c_cnt_max_l = (64'd1 << CNT_W) - 64'd1;
  localparam logic [CNT_W-1:0] c_cnt_max  = '1;

  generate
    if (!(MIN_SPACE < BIT1_THRESH && BIT1_THRESH < TIMEOUT &&
          64'(TIMEOUT) <= c_cnt_max_l && SYNC_STAGES >= 2 && FRAME_BITS >= 2))
    begin : g_param_error
      $error("ir_frame_decoder: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t                  r_state;
  logic [SYNC_STAGES-1:0]  r_sync;
  logic                    r_ir_d;
  logic [CNT_W-1:0]        r_len_cnt;
  logic [FRAME_BITS-1:0]   r_shift;
  logic [c_bc_w-1:0]       r_bit_count;
  logic [FRAME_BITS-1:0]   r_frame_data;
  logic                    r_frame_valid;
  logic                    r_error;
  logic                    r_err_timeout;

  logic                    w_ir_s;
  logic                    w_fall;
  logic                    w_rise;
  logic                    w_short;
  logic                    w_bit;
  logic                    w_timeout;
  logic [FRAME_BITS-1:0]   w_shift_next;

  assign w_ir_s       = r_sync[SYNC_STAGES-1];
  assign w_fall       = r_ir_d & ~w_ir_s;
  assign w_rise       = ~r_ir_d & w_ir_s;
  assign w_short      = r_len_cnt < CNT_W'(MIN_SPACE);
  assign w_bit        = r_len_cnt > CNT_W'(BIT1_THRESH);
  assign w_timeout    = r_len_cnt == CNT_W'(TIMEOUT);
  // LSB-first: new bits enter at the top so the first bit ends at bit 0.
  assign w_shift_next = {w_bit, r_shift[FRAME_BITS-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '1;
      r_ir_d <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ir_in};
      r_ir_d <= w_ir_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len_cnt <= '0;
    end else if (w_fall || w_rise) begin
      r_len_cnt <= '0;
    end else if (r_len_cnt != c_cnt_max) begin
      r_len_cnt <= r_len_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_shift       <= '0;
      r_bit_count   <= '0;
      r_frame_data  <= '0;
      r_frame_valid <= 1'b0;
      r_error       <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_error       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state     <= RECV;
            r_shift     <= '0;
            r_bit_count <= '0;
          end
        end
        RECV: begin
          if (w_fall) begin
            if (w_short) begin
              r_error       <= 1'b1;
              r_err_timeout <= 1'b0;
              r_bit_count   <= '0;
              r_state       <= IDLE;
            end else if (r_bit_count == c_bc_w'(FRAME_BITS - 1)) begin
              r_shift       <= w_shift_next;
              r_frame_data  <= w_shift_next;
              r_frame_valid <= 1'b1;
              r_bit_count   <= '0;
              r_state       <= IDLE;
            end else begin
              r_shift     <= w_shift_next;
              r_bit_count <= r_bit_count + c_bc_w'(1);
            end
          end else if (!w_rise && w_timeout) begin
            // A rise on the same cycle restarts timing, so it outranks timeout.
            r_error       <= 1'b1;
            r_err_timeout <= 1'b1;
            r_bit_count   <= '0;
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign frame_data  = r_frame_data;
  assign frame_valid = r_frame_valid;
  assign error       = r_error;
  assign err_timeout = r_err_timeout;
  assign busy        = (r_state == RECV);
  assign bit_count   = r_bit_count;

endmodule
`default_nettype wire

// File: tb/tb_ir_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ir_frame_decoder
// Purpose  : Randomised and directed bench for ir_frame_decoder against an
//            event-level model of line timing and frame assembly.
// Revision : 1.0
// ============================================================================
module tb_ir_frame_decoder;

  localparam int FB     = 4;
  localparam int CW     = 8;
  localparam int SYNC   = 2;
  localparam int MINS   = 3;
  localparam int THR    = 10;
  localparam int TMO    = 50;
  localparam int LENMAX = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ir_in = 1'b1;
  logic [FB-1:0] frame_data;
  logic          frame_valid;
  logic          error;
  logic          err_timeout;
  logic          busy;
  logic [2:0]    bit_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_dut_valid = 0;
  int n_dut_err   = 0;
  bit started = 1'b0;

  ir_frame_decoder #(
    .FRAME_BITS(FB), .CNT_W(CW), .SYNC_STAGES(SYNC),
    .MIN_SPACE(MINS), .BIT1_THRESH(THR), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .ir_in(ir_in),
    .frame_data(frame_data), .frame_valid(frame_valid), .error(error),
    .err_timeout(err_timeout), .busy(busy), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  // Model: raw line history, run length of the synchronised level, bit list.
  bit      hq[$];
  int      m_len;
  bit      m_busy;
  bit      m_bits[$];
  int      m_frame;
  bit      m_valid, m_err, m_errto;

  task automatic model_reset();
    hq = {1'b1, 1'b1, 1'b1};
    m_len = 0; m_busy = 0; m_bits = {};
    m_frame = 0; m_valid = 0; m_err = 0; m_errto = 0;
  endtask

  task automatic model_step(input bit raw);
    bit cur, prv, fall, rise;
    int s, word;
    cur  = hq[SYNC-1];
    prv  = hq[SYNC];
    fall = prv && !cur;
    rise = !prv && cur;
    s = m_len;
    m_valid = 0; m_err = 0;
    if (m_busy) begin
      if (fall) begin
        if (s < MINS) begin
          m_err = 1; m_errto = 0; m_busy = 0; m_bits = {};
        end else begin
          m_bits.push_back(s > THR);
          if (m_bits.size() == FB) begin
            word = 0;
            foreach (m_bits[i]) word += int'(m_bits[i]) << i;
            m_frame = word; m_valid = 1; m_busy = 0; m_bits = {};
          end
        end
      end else if (!rise && s == TMO) begin
        m_err = 1; m_errto = 1; m_busy = 0; m_bits = {};
      end
    end else if (fall) begin
      m_busy = 1; m_bits = {};
    end
    m_len = (fall || rise) ? 0 : ((m_len < LENMAX) ? m_len + 1 : LENMAX);
    hq.push_front(raw);
    void'(hq.pop_back());
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_step(ir_in);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (started) begin
      check("frame_valid", 32'(frame_valid), 32'(m_valid));
      check("error",       32'(error),       32'(m_err));
      check("err_timeout", 32'(err_timeout), 32'(m_errto));
      check("busy",        32'(busy),        32'(m_busy));
      check("bit_count",   32'(bit_count),   32'(m_bits.size()));
      check("frame_data",  32'(frame_data),  32'(m_frame));
      check("len_cnt",     32'(dut.r_len_cnt), 32'(m_len));
      if (frame_valid) n_dut_valid++;
      if (error) n_dut_err++;
    end
  end

  task automatic drive(input logic val, input int n);
    @(negedge clk);
    ir_in = val;
    repeat (n - 1) @(negedge clk);
  endtask

  function automatic int pick_mark();
    return ($urandom_range(0, 15) == 0) ? 55 : int'($urandom_range(1, 8));
  endfunction

  function automatic int pick_space();
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0) return 55;
    if (r < 3)  return int'($urandom_range(1, 3));
    return int'($urandom_range(4, 25));
  endfunction

  initial begin : stim
    int v0, e0;
    repeat (3) @(negedge clk);
    started = 1'b1;
    reset = 1'b0;

    // Idle line: nothing happens.
    drive(1, 100);
    check("s1_busy", 32'(busy), 32'd0);
    check("s1_frame", 32'(frame_data), 32'd0);
    check("s1_pulses", 32'(n_dut_valid + n_dut_err), 32'd0);

    // Frame 0,1,0,1 -> 4'b1010 with a 3-edge pulse latency.
    drive(0, 5); drive(1, 5);
    drive(0, 5); drive(1, 20);
    drive(0, 5); drive(1, 5);
    drive(0, 5); drive(1, 20);
    @(negedge clk);
    ir_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("s2_early", 32'(frame_valid), 32'd0);
    @(posedge clk);
    #1 check("s2_latency", 32'(frame_valid), 32'd1);
    drive(0, 5);
    drive(1, 10);
    check("s2_frame", 32'(frame_data), 32'hA);
    check("s2_busy", 32'(busy), 32'd0);
    check("s2_one_pulse", 32'(n_dut_valid), 32'd1);

    // Glitch space.
    e0 = n_dut_err;
    drive(0, 5); drive(1, 2); drive(0, 5); drive(1, 10);
    check("s3_err", 32'(n_dut_err - e0), 32'd1);
    check("s3_cause", 32'(err_timeout), 32'd0);
    check("s3_bitcnt", 32'(bit_count), 32'd0);
    check("s3_frame", 32'(frame_data), 32'hA);

    // Stuck mark, then a fresh frame that times out in a space.
    e0 = n_dut_err;
    drive(0, 60);
    check("s4_err", 32'(n_dut_err - e0), 32'd1);
    check("s4_cause", 32'(err_timeout), 32'd1);
    check("s4_idle", 32'(busy), 32'd0);
    drive(1, 10); drive(0, 5);
    check("s4_restart", 32'(busy), 32'd1);
    drive(1, 60);
    check("s4_space_to", 32'(busy), 32'd0);

    // Reset mid-frame, then an all-ones frame.
    v0 = n_dut_valid;
    drive(0, 5); drive(1, 20); drive(0, 5); drive(1, 20); drive(0, 5);
    check("s5_two_bits", 32'(bit_count), 32'd2);
    @(negedge clk);
    reset = 1'b1; ir_in = 1'b1;
    #1;
    check("s5_rst_busy", 32'(busy), 32'd0);
    check("s5_rst_bits", 32'(bit_count), 32'd0);
    check("s5_rst_frame", 32'(frame_data), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("s5_no_pulse", 32'(n_dut_valid - v0), 32'd0);
    drive(1, 10);
    drive(0, 5);
    for (int i = 0; i < 4; i++) begin drive(1, 20); drive(0, 5); end
    drive(1, 10);
    check("s5_frame", 32'(frame_data), 32'hF);

    // Long idle saturates the counter; next fall still starts a frame.
    drive(1, 300);
    check("s6_sat", 32'(dut.r_len_cnt), 32'd255);
    drive(0, 5);
    check("s6_recv", 32'(busy), 32'd1);

    // Random traffic.
    for (int f = 0; f < 40; f++) begin
      drive(1, int'($urandom_range(3, 15)));
      for (int b = 0; b < int'($urandom_range(1, 5)); b++) begin
        drive(0, pick_mark());
        drive(1, pick_space());
      end
      drive(0, int'($urandom_range(1, 6)));
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
      end
    end
    drive(1, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ir_frame_decoder.md
Name: ir_frame_decoder

Overview:
- Parametrised IR receiver front end. Synchronises the raw IR line and measures the duration of every mark and space.
- Decodes each space length into a 0/1 bit and assembles FRAME_BITS bits into a frame word.
- Flags glitches and stuck lines as errors.
- Supersedes the fixed-threshold single-counter pulse timer and feeds the command state machine with whole, validated frames.

Parameters:
- FRAME_BITS, 32: bits per frame.
- CNT_W, 32: width of the duration counter; the counter saturates at 2^CNT_W-1.
- SYNC_STAGES, 2: synchroniser flops on ir_in, minimum 2.
- MIN_SPACE, 200: a space shorter than this many cycles is a glitch.
- BIT1_THRESH, 1000: a space longer than this decodes to 1, otherwise 0.
- TIMEOUT, 177127: a mark or space reaching this length mid-frame is an error.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- ir_in  input  1  raw IR line, asynchronous; idle/space = 1, mark = 0
- frame_data  output  FRAME_BITS  last complete frame, LSB = first bit received
- frame_valid  output  1  one-cycle pulse when frame_data updates
- error  output  1  one-cycle pulse on glitch or timeout
- err_timeout  output  1  cause of the last error (1 = timeout, 0 = glitch); held until the next error
- busy  output  1  high while in RECV
- bit_count  output  $clog2(FRAME_BITS+1)  bits received in the current frame

Behaviour:
- Reset (async, active-high) values:
  - state = IDLE
  - all synchroniser flops = 1
  - len_cnt = 0, shift register = 0, bit_count = 0
  - frame_data = 0, frame_valid = 0, error = 0, err_timeout = 0
  - Reset mid-frame discards the partial frame and produces no pulse.
- Synchroniser and edge detect:
  - ir_s is the last synchroniser stage; ir_d is ir_s delayed one cycle.
  - fall = ir_d & ~ir_s; rise = ~ir_d & ir_s.
- Duration counter len_cnt:
  - Cleared to 0 on any clock edge where fall or rise is true.
  - Otherwise increments by 1, saturating at 2^CNT_W-1 (no wrap).
  - S = value of len_cnt at the clock edge where fall is detected, i.e. the length of the space just ended.
- FSM, state IDLE:
  - On fall: go to RECV, clear shift register and bit_count. The leading space is not decoded.
  - Timeouts are ignored in IDLE.
- FSM, state RECV, on fall:
  - If S < MIN_SPACE: error=1, err_timeout=0, go to IDLE, discard the frame.
  - Otherwise bit = (S > BIT1_THRESH). Shift the bit in LSB-first, so after FRAME_BITS bits the first bit sits at bit 0. Increment bit_count.
  - If bit_count reaches FRAME_BITS: load frame_data, set frame_valid=1 for exactly one cycle, reset bit_count to 0, go to IDLE.
- FSM, state RECV, timeout:
  - If len_cnt == TIMEOUT at either line level: error=1, err_timeout=1, go to IDLE, discard the frame.
  - Priority: an edge on the same cycle wins over timeout. A frame completion cannot coincide with a timeout because the edge clears len_cnt.
- Latency:
  - A raw ir_in fall reaches ir_s after SYNC_STAGES clock edges.
  - frame_valid or error is registered one further edge later, so latency is SYNC_STAGES+1 clock edges from raw input to pulse.
- busy = (state == RECV).
- frame_data holds its value through errors and IDLE periods; it changes only together with frame_valid.
- Back-to-back frames: the fall that completes a frame does not start the next one. The next fall starts a new frame from IDLE.
- Parameter-check assertions: MIN_SPACE < BIT1_THRESH < TIMEOUT < 2^CNT_W.

Test Plan:
All scenarios use FRAME_BITS=4, SYNC_STAGES=2, MIN_SPACE=3, BIT1_THRESH=10, TIMEOUT=50.
1. Reset, then hold ir_in=1 for 100 cycles → all outputs 0, busy=0, no pulses.
2. Leading fall, then four mark(5)/space pairs with spaces 5, 20, 5, 20, then a final fall → frame_data=4'b1010, single frame_valid pulse 3 clock edges after the final raw fall, busy back to 0.
3. Start a frame, then a space of 2 cycles → error pulse, err_timeout=0, bit_count=0, frame_data unchanged from scenario 2.
4. Start a frame, then hold ir_in=0 for 60 cycles → error pulse when len_cnt hits 50, err_timeout=1, state IDLE; the later rise/fall starts a fresh frame.
5. Assert reset after 2 of 4 bits → outputs return to reset values immediately and asynchronously; a following full frame of all-1 spaces (20,20,20,20) gives frame_data=4'b1111.
6. Line idle for 300 cycles with CNT_W=8 in IDLE → len_cnt saturates at 255 without wrapping; the next fall enters RECV normally.
